byte_serial_adder: RTL and testbench

BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

---
 rtl/byte_serial_adder_pkg.sv | 11 +
 rtl/byte_serial_adder_fa8.sv | 23 ++
 rtl/byte_serial_adder.sv | 107 ++++++++++
 tb/tb_byte_serial_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial adder.
package byte_serial_adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/byte_serial_adder_fa8.sv
// Combinational 8-bit full adder used as the byte slice of the serial adder.
module fullAdder_8bit
    import byte_serial_adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] carry;

    always_comb begin
        carry[0] = cin;
        for (int unsigned i = 0; i < BYTE_W; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[BYTE_W];
    end

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-byte add/subtract, one operand byte pair per beat, LSB first.
// Optional signed-overflow output enabled by macro BYTE_SERIAL_ADDER_OVF_EN.
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_x,
    input  logic [BYTE_W-1:0] in_y,
    input  logic              in_sub,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_err
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    ,
    output logic              out_ovf
`endif
);

    state_t            state;
    logic              carry_q;
    logic              sub_q;
    logic [7:0]        beat_cnt;

    logic              accept;
    logic              first;
    logic              sub_eff;
    logic              cin;
    logic [BYTE_W-1:0] y_eff;
    logic [BYTE_W-1:0] sum;
    logic              cout;
    logic [7:0]        beat_num;
    logic              at_max;
    logic              close;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign first    = (state == IDLE);
    assign sub_eff  = first ? in_sub : sub_q;
    assign cin      = first ? in_sub : carry_q;
    assign y_eff    = sub_eff ? ~in_y : in_y;
    assign beat_num = beat_cnt + 8'd1;
    assign at_max   = (beat_num == 8'(MAX_BEATS));
    assign close    = in_last || at_max;

    fullAdder_8bit u_fa (
        .a    (in_x),
        .b    (y_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

`ifdef BYTE_SERIAL_ADDER_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit.
    logic carry7;
    assign carry7 = in_x[BYTE_W-1] ^ y_eff[BYTE_W-1] ^ sum[BYTE_W-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_err   <= 1'b0;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_last  <= close;
            out_cout  <= close & cout;
            out_err   <= at_max & !in_last;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
            out_ovf   <= close & (carry7 ^ cout);
`endif
            carry_q   <= cout;
            if (first) begin
                sub_q <= in_sub;
            end
            if (close) begin
                state    <= IDLE;
                beat_cnt <= '0;
            end else begin
                state    <= BUSY;
                beat_cnt <= beat_num;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder: directed cases then random traffic
// checked against a whole-packet arithmetic model.
module tb_byte_serial_adder;

    localparam int unsigned MB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_y;
    logic       in_sub;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_err;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    logic       out_ovf;
`endif

    always #5 clk = ~clk;

    byte_serial_adder #(.MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_err   (out_err)
`ifdef BYTE_SERIAL_ADDER_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    typedef struct {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       err;
        logic       ovf;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_n    = 0;
    logic [63:0] mx, my;
    logic        msub;
    logic        stall_prev = 1'b0;
    logic [11:0] snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result byte n is the n-th byte of (X + Yeff + sub) over the bytes seen so far.
    task automatic model_beat(input logic [7:0] x, input logic [7:0] y,
                              input logic sub, input logic last);
        int unsigned w;
        logic [63:0] mask, yeff, r;
        logic        sx, sy, sr;
        exp_t        e;
        if (cur_n == 0) begin
            msub = sub;
            mx   = '0;
            my   = '0;
        end
        mx = mx | (64'(x) << (8 * cur_n));
        my = my | (64'(y) << (8 * cur_n));
        cur_n++;
        w    = 8 * cur_n;
        mask = (64'd1 << w) - 64'd1;
        yeff = msub ? (~my & mask) : my;
        r    = mx + yeff + 64'(msub);
        sx   = mx[w-1];
        sy   = yeff[w-1];
        sr   = r[w-1];
        e.sum  = 8'((r >> (w - 8)) & 64'hFF);
        e.last = last || (cur_n == MB);
        e.cout = r[w];
        e.err  = (cur_n == MB) && !last;
        e.ovf  = (sx == sy) && (sr != sx);
        exp_q.push_back(e);
        if (e.last) cur_n = 0;
    endtask

    // Called just after a falling edge; evaluates transfers for the coming rising edge.
    task automatic step();
        logic in_fire, out_fire;
        exp_t e;
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (stall_prev)
            chk("hold", {out_valid, out_sum, out_last, out_err, out_cout}, 64'(snap));
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", 64'(out_sum), 64'(e.sum));
                chk("last", 64'(out_last), 64'(e.last));
                chk("err", 64'(out_err), 64'(e.err));
                if (e.last) begin
                    chk("cout", 64'(out_cout), 64'(e.cout));
`ifdef BYTE_SERIAL_ADDER_OVF_EN
                    chk("ovf", 64'(out_ovf), 64'(e.ovf));
`endif
                end
            end
        end
        stall_prev = out_valid && !out_ready;
        snap = {out_valid, out_sum, out_last, out_err, out_cout};
        if (in_fire) model_beat(in_x, in_y, in_sub, in_last);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y,
                        input logic sub, input logic last);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_sub   = sub;
        in_last  = last;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_flags", {out_last, out_cout, out_err}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single-beat add
        send(8'h6B, 8'h5D, 1'b0, 1'b1);
        chk("add1_valid", 64'(out_valid), 64'd1);
        chk("add1_sum", 64'(out_sum), 64'hC8);
        chk("add1_cout", {out_last, out_cout}, 64'b10);

        // two-beat add 0x01FF + 0x0001
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("add2_b0", {out_sum, out_last}, {8'h00, 1'b0});
        send(8'h01, 8'h00, 1'b0, 1'b1);
        chk("add2_b1", {out_sum, out_last, out_cout}, {8'h02, 1'b1, 1'b0});

        // single-beat subtract
        send(8'h40, 8'h11, 1'b1, 1'b1);
        chk("sub1", {out_sum, out_last, out_cout}, {8'h2F, 1'b1, 1'b1});

        // backpressure: stalled output with a pending input beat
        send(8'h10, 8'h20, 1'b0, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 8'h33;
        in_y      = 8'h44;
        in_sub    = 1'b0;
        in_last   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum_held", 64'(out_sum), 64'h30);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_after", {out_valid, out_sum}, {1'b1, 8'h77});
        step();

        // truncation at MAX_BEATS
        for (int i = 0; i < 5; i++) begin
            send(8'h01, 8'h01, 1'b0, 1'b0);
            if (i == 3) chk("trunc_close", {out_last, out_err}, 64'b11);
            if (i == 4) chk("trunc_next", {out_sum, out_last, out_err}, {8'h02, 1'b0, 1'b0});
        end
        send(8'h01, 8'h01, 1'b0, 1'b1);
        step();

        // reset mid-packet
        send(8'h12, 8'h34, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        cur_n      = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h7F, 8'h01, 1'b0, 1'b1);
        chk("post_rst", {out_sum, out_last, out_cout}, {8'h80, 1'b1, 1'b0});
`ifdef BYTE_SERIAL_ADDER_OVF_EN
        chk("post_rst_ovf", 64'(out_ovf), 64'd1);
`endif
        step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_x      = 8'($urandom);
            in_y      = 8'($urandom);
            in_sub    = 1'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
